// File: rtl/sim_commit_tx.sv
// Commit-side half of the co-simulation PC/instruction checker: buffers retired
// instructions, asks the reference simulator to step each PC and compares results.
module sim_commit_tx #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [ILEN-1:0] commit_insn,
   output logic            commit_ready,
   output logic            req_valid,
   output logic [XLEN-1:0] req_pc,
   input  logic            req_ready,
   input  logic            rsp_valid,
   input  logic [XLEN-1:0] rsp_pc,
   input  logic [ILEN-1:0] rsp_insn,
   output logic            mismatch,
   output logic [XLEN-1:0] mm_pc,
   output logic [ILEN-1:0] mm_insn_dut,
   output logic [ILEN-1:0] mm_insn_ref,
   output logic            proto_err,
   output logic [31:0]     checked_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, HALT} state_t;

   state_t          state_q, state_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic            commit_ready_q, commit_ready_d;
   logic            mismatch_q, mismatch_d;
   logic [XLEN-1:0] mm_pc_q, mm_pc_d;
   logic [ILEN-1:0] mm_insn_dut_q, mm_insn_dut_d;
   logic [ILEN-1:0] mm_insn_ref_q, mm_insn_ref_d;
   logic            proto_err_q, proto_err_d;
   logic [31:0]     checked_cnt_q, checked_cnt_d;

   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [ILEN-1:0] insn_mem_q [DEPTH];

   logic            push, pop, empty, full_d, rec_match;
   logic [XLEN-1:0] head_pc;
   logic [ILEN-1:0] head_insn;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign head_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
   assign head_insn = insn_mem_q[rd_ptr_q[AW-1:0]];
   assign rec_match = (rsp_pc == head_pc) && (rsp_insn == head_insn);
   assign push      = commit_valid && commit_ready_q;

   // Storage carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q[AW-1:0]]   <= commit_pc;
         insn_mem_q[wr_ptr_q[AW-1:0]] <= commit_insn;
      end
   end

   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      mismatch_d    = mismatch_q;
      mm_pc_d       = mm_pc_q;
      mm_insn_dut_d = mm_insn_dut_q;
      mm_insn_ref_d = mm_insn_ref_q;
      proto_err_d   = proto_err_q;
      checked_cnt_d = checked_cnt_q;

      case (state_q)
         IDLE: begin
            if (rsp_valid) proto_err_d = 1'b1;
            if (!empty)    state_d     = REQ;
         end
         REQ: begin
            if (rsp_valid) proto_err_d = 1'b1;
            if (req_ready) state_d     = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (rsp_valid) begin
               if (rec_match) begin
                  pop     = 1'b1;
                  state_d = IDLE;
                  if (checked_cnt_q != 32'hFFFF_FFFF) checked_cnt_d = checked_cnt_q + 32'd1;
               end else begin
                  mismatch_d    = 1'b1;
                  mm_pc_d       = head_pc;
                  mm_insn_dut_d = head_insn;
                  mm_insn_ref_d = rsp_insn;
                  state_d       = HALT;
               end
            end
         end
         default: state_d = HALT;
      endcase

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      // Ready is registered from the next occupancy, so a pop frees a slot one cycle later.
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      commit_ready_d = !full_d && (state_d != HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         commit_ready_q <= 1'b0;
         mismatch_q     <= 1'b0;
         mm_pc_q        <= '0;
         mm_insn_dut_q  <= '0;
         mm_insn_ref_q  <= '0;
         proto_err_q    <= 1'b0;
         checked_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         commit_ready_q <= commit_ready_d;
         mismatch_q     <= mismatch_d;
         mm_pc_q        <= mm_pc_d;
         mm_insn_dut_q  <= mm_insn_dut_d;
         mm_insn_ref_q  <= mm_insn_ref_d;
         proto_err_q    <= proto_err_d;
         checked_cnt_q  <= checked_cnt_d;
      end
   end

   assign commit_ready = commit_ready_q;
   assign req_valid    = (state_q == REQ);
   assign req_pc       = (state_q == REQ) ? head_pc : '0;
   assign mismatch     = mismatch_q;
   assign mm_pc        = mm_pc_q;
   assign mm_insn_dut  = mm_insn_dut_q;
   assign mm_insn_ref  = mm_insn_ref_q;
   assign proto_err    = proto_err_q;
   assign checked_cnt  = checked_cnt_q;

endmodule

// File: tb/tb_sim_commit_tx.sv
// Scoreboard bench for sim_commit_tx: accepted commits are queued as expected
// records and checked against each simulator request and the compare result.
module tb_sim_commit_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        commit_valid = 1'b0;
   logic [63:0] commit_pc = '0;
   logic [31:0] commit_insn = '0;
   logic        commit_ready;
   logic        req_valid;
   logic [63:0] req_pc;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [63:0] rsp_pc = '0;
   logic [31:0] rsp_insn = '0;
   logic        mismatch;
   logic [63:0] mm_pc;
   logic [31:0] mm_insn_dut;
   logic [31:0] mm_insn_ref;
   logic        proto_err;
   logic [31:0] checked_cnt;

   sim_commit_tx #(.XLEN(64), .ILEN(32), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_insn(commit_insn),
      .commit_ready(commit_ready),
      .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_pc(rsp_pc), .rsp_insn(rsp_insn),
      .mismatch(mismatch), .mm_pc(mm_pc), .mm_insn_dut(mm_insn_dut),
      .mm_insn_ref(mm_insn_ref), .proto_err(proto_err), .checked_cnt(checked_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] insn;
   } rec_t;

   rec_t        exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] exp_cnt = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [63:0] pc, input logic [31:0] insn);
      int t = 0;
      commit_valid = 1'b1;
      commit_pc    = pc;
      commit_insn  = insn;
      while (!commit_ready && t < 50) begin
         tick();
         t++;
      end
      if (!commit_ready) begin
         chk("commit_timeout", 64'd0, 64'd1);
         commit_valid = 1'b0;
         return;
      end
      tick();
      commit_valid = 1'b0;
      exp_q.push_back({pc, insn});
      $display("commit   pc=%h insn=%h", pc, insn);
   endtask

   task automatic wait_req();
      int t = 0;
      while (!req_valid && t < 50) begin
         tick();
         t++;
      end
      if (!req_valid) chk("req_timeout", 64'd0, 64'd1);
   endtask

   task automatic serve(input bit corrupt);
      rec_t r;
      wait_req();
      if (!req_valid) return;
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 64'd1, 64'd0);
         return;
      end
      r = exp_q.pop_front();
      chk("req_pc", req_pc, r.pc);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk("req_drop", {63'd0, req_valid}, 64'd0);
      rsp_valid = 1'b1;
      rsp_pc    = r.pc;
      rsp_insn  = corrupt ? 32'h0000_0073 : r.insn;
      tick();
      rsp_valid = 1'b0;
      if (!corrupt) exp_cnt++;
      chk("checked_cnt", {32'd0, checked_cnt}, {32'd0, exp_cnt});
      chk("mismatch", {63'd0, mismatch}, {63'd0, corrupt});
      $display("response pc=%h insn=%h ref_insn=%h cnt=%0d", r.pc, r.insn, rsp_insn, checked_cnt);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},   {63'd0, commit_ready}, 64'd0);
      chk({tag, "_rvalid"},  {63'd0, req_valid},    64'd0);
      chk({tag, "_rpc"},     req_pc,                64'd0);
      chk({tag, "_mm"},      {63'd0, mismatch},     64'd0);
      chk({tag, "_mmpc"},    mm_pc,                 64'd0);
      chk({tag, "_mmdut"},   {32'd0, mm_insn_dut},  64'd0);
      chk({tag, "_mmref"},   {32'd0, mm_insn_ref},  64'd0);
      chk({tag, "_perr"},    {63'd0, proto_err},    64'd0);
      chk({tag, "_cnt"},     {32'd0, checked_cnt},  64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", {63'd0, commit_ready}, 64'd1);

      // Single matching record
      commit(64'h8000_0000, 32'h0000_0013);
      serve(1'b0);
      repeat (3) tick();
      chk("idle_after_one", {63'd0, req_valid}, 64'd0);

      // Burst of DEPTH commits with the simulator stalled
      for (int i = 0; i < 8; i++) commit(64'h8000_1000 + 64'(i * 4), 32'h0010_0093 + 32'(i));
      chk("full_ready", {63'd0, commit_ready}, 64'd0);
      commit_valid = 1'b1;
      commit_pc    = 64'hDEAD_BEEF;
      commit_insn  = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rvalid", {63'd0, req_valid}, 64'd1);
         chk("stall_rpc", req_pc, 64'h8000_1000);
         chk("stall_ready", {63'd0, commit_ready}, 64'd0);
         tick();
      end
      commit_valid = 1'b0;
      for (int i = 0; i < 8; i++) serve(1'b0);
      repeat (4) tick();
      chk("drained", {63'd0, req_valid}, 64'd0);
      chk("burst_cnt", {32'd0, checked_cnt}, 64'd9);

      // Response while idle
      chk("perr_clear", {63'd0, proto_err}, 64'd0);
      rsp_valid = 1'b1;
      rsp_pc    = 64'h8000_0000;
      rsp_insn  = 32'h0000_0013;
      tick();
      rsp_valid = 1'b0;
      chk("perr_set", {63'd0, proto_err}, 64'd1);
      chk("perr_cnt", {32'd0, checked_cnt}, {32'd0, exp_cnt});

      // Reset while a request is outstanding
      for (int i = 0; i < 3; i++) commit(64'h8000_2000 + 64'(i * 4), 32'h0000_0013);
      wait_req();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      exp_q.delete();
      exp_cnt = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_ready", {63'd0, commit_ready}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_empty", {63'd0, req_valid}, 64'd0);
      end

      // Mismatch latches and halts
      commit(64'h8000_0004, 32'h0000_0013);
      serve(1'b1);
      chk("mm_pc", mm_pc, 64'h8000_0004);
      chk("mm_dut", {32'd0, mm_insn_dut}, 64'h13);
      chk("mm_ref", {32'd0, mm_insn_ref}, 64'h73);
      commit_valid = 1'b1;
      commit_pc    = 64'h8000_0008;
      commit_insn  = 32'h0000_0013;
      rsp_valid    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halt_ready", {63'd0, commit_ready}, 64'd0);
         chk("halt_rvalid", {63'd0, req_valid}, 64'd0);
      end
      commit_valid = 1'b0;
      rsp_valid    = 1'b0;
      chk("halt_perr", {63'd0, proto_err}, 64'd0);
      chk("halt_mmpc", mm_pc, 64'h8000_0004);
      chk("halt_cnt", {32'd0, checked_cnt}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
